// File: rtl/roi_capture.sv
// roi_capture: grabs a decimated rectangular ROI from a raster pixel stream,
// buffers it in a FIFO and streams it out over valid/ready with a last flag.
//
// Ports:
//   clock, reset (async, active-low)
//   enable        arm capture of the next frame (sampled in IDLE only)
//   screen_x_pos  raster column; screen_y_pos raster row
//   pix_valid     position and test_pixel valid this cycle
//   test_pixel    camera pixel at the current position
//   out_pixel     ROI pixel; out_valid/out_ready handshake; out_last ROI end
//   frame_done    one-cycle pulse once capture and drain are complete
//   busy          not idle; err sticky overflow / mid-capture restart
module roi_capture #(
    parameter int PIXEL_W    = 9,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int ROI_X0     = 16,
    parameter int ROI_Y0     = 8,
    parameter int ROI_W      = 28,
    parameter int ROI_H      = 28,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [X_W-1:0]     screen_x_pos,
    input  logic [Y_W-1:0]     screen_y_pos,
    input  logic               pix_valid,
    input  logic [PIXEL_W-1:0] test_pixel,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               frame_done,
    output logic               busy,
    output logic               err
);

    localparam int CW    = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam int TOTAL = ROI_W * ROI_H;
    localparam int NW    = $clog2(TOTAL + 1);
    localparam int DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CLW   = (ROI_W > 1) ? $clog2(ROI_W) : 1;
    localparam int RLW   = (ROI_H > 1) ? $clog2(ROI_H) : 1;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW   = PW + 1;
    localparam int EW    = PIXEL_W + 1;

    localparam logic [CW-1:0]  X_LO    = CW'(ROI_X0);
    localparam logic [CW-1:0]  X_HI    = CW'(ROI_X0 + ROI_W * DECIM);
    localparam logic [CW-1:0]  Y_LO    = CW'(ROI_Y0);
    localparam logic [CW-1:0]  Y_HI    = CW'(ROI_Y0 + ROI_H * DECIM);
    localparam logic [DCW-1:0] PH_END  = DCW'(DECIM - 1);
    localparam logic [CLW-1:0] COL_END = CLW'(ROI_W - 1);
    localparam logic [RLW-1:0] ROW_END = RLW'(ROI_H - 1);
    localparam logic [NW-1:0]  CNT_END = NW'(TOTAL);
    localparam logic [FCW-1:0] F_FULL  = FCW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t         state;
    logic [NW-1:0]  cnt;
    logic [NW-1:0]  cnt_base;
    logic [NW-1:0]  cnt_next;
    logic [DCW-1:0] cph_q, cph, rph_q, rph;
    logic [CLW-1:0] col_q, col;
    logic [RLW-1:0] row_q, row;
    logic [CW-1:0]  xw, yw;
    logic           fs, start, restart, active;
    logic           in_x, in_y, qual, last, cap_done;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [FCW-1:0] fcnt;
    logic           full, pop, push_ok, drop;
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [EW-1:0]  head;

    assign xw = CW'(screen_x_pos);
    assign yw = CW'(screen_y_pos);

    assign fs      = pix_valid && (screen_x_pos == '0) && (screen_y_pos == '0);
    assign start   = (state == IDLE) && enable && fs;
    assign restart = (state == CAPTURE) && fs;
    assign active  = (state == CAPTURE) || start;

    // Phase/index values seen by the current pixel: the column side
    // re-zeroes at the ROI's first column, the row side steps on every
    // x==0 pixel and re-zeroes at the ROI's first row.
    always_comb begin
        cph = cph_q;
        col = col_q;
        rph = rph_q;
        row = row_q;
        if (xw == X_LO) begin
            cph = '0;
            col = '0;
        end
        if (screen_x_pos == '0) begin
            if (yw == Y_LO) begin
                rph = '0;
                row = '0;
            end else if (rph_q == PH_END) begin
                rph = '0;
                row = row_q + RLW'(1);
            end else begin
                rph = rph_q + DCW'(1);
            end
        end
    end

    assign in_x = (xw >= X_LO) && (xw < X_HI);
    assign in_y = (yw >= Y_LO) && (yw < Y_HI);
    assign qual = active && pix_valid && in_x && in_y &&
                  (cph == '0) && (rph == '0);
    assign last = (row == ROW_END) && (col == COL_END);

    assign cnt_base = (start || restart) ? '0 : cnt;
    assign cnt_next = cnt_base + NW'(qual);
    assign cap_done = qual && (cnt_next == CNT_END);

    assign out_valid = (fcnt != '0);
    assign full      = (fcnt == F_FULL);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a push into a full
    // FIFO is still accepted then.
    assign push_ok   = qual && (!full || pop);
    assign drop      = qual && full && !pop;

    assign head      = mem[rd_ptr];
    assign out_pixel = out_valid ? head[PIXEL_W-1:0] : '0;
    assign out_last  = out_valid && head[PIXEL_W];
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= {last, test_pixel};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cph_q      <= '0;
            col_q      <= '0;
            rph_q      <= '0;
            row_q      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fcnt       <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (pix_valid) begin
                rph_q <= rph;
                row_q <= row;
                if (cph == PH_END) begin
                    cph_q <= '0;
                    col_q <= col + CLW'(1);
                end else begin
                    cph_q <= cph + DCW'(1);
                    col_q <= col;
                end
            end

            if (active)
                cnt <= cnt_next;

            unique case (state)
                IDLE: begin
                    if (start)
                        state <= cap_done ? DRAIN : CAPTURE;
                end
                CAPTURE: begin
                    if (cap_done)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (fcnt == '0) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (start)
                err <= 1'b0;
            if (restart || drop)
                err <= 1'b1;

            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({push_ok, pop})
                2'b10:   fcnt <= fcnt + FCW'(1);
                2'b01:   fcnt <= fcnt - FCW'(1);
                default: fcnt <= fcnt;
            endcase
        end
    end

endmodule

// File: tb/tb_roi_capture.sv
// tb_roi_capture: scenario table plus hand sequences for roi_capture.
// Expected beats come from a raster-position model of the ROI.
module tb_roi_capture;

    localparam int NC = 80;
    localparam int NR = 66;
    localparam int RX = 16;
    localparam int RY = 8;
    localparam int RW = 28;
    localparam int RH = 28;
    localparam int DC = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] screen_x_pos;
    logic [9:0] screen_y_pos;
    logic       pix_valid;
    logic [8:0] test_pixel;
    logic [8:0] out_pixel;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_done;
    logic       busy;
    logic       err;

    always #5 clock = ~clock;

    roi_capture dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .screen_x_pos(screen_x_pos),
        .screen_y_pos(screen_y_pos),
        .pix_valid   (pix_valid),
        .test_pixel  (test_pixel),
        .out_pixel   (out_pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_done  (frame_done),
        .busy        (busy),
        .err         (err)
    );

    int errors = 0;
    int checks = 0;

    logic [9:0] got[$];
    logic [9:0] exp_q[$];
    logic [8:0] img[NR][NC];
    int         rmode;
    logic       rdy_var;
    int         cyc;
    int         done_cnt;
    bit         busy_seen;
    bit         prev_stall;
    logic [9:0] hold;
    int         stab_bad;

    typedef struct {
        int mode;
        int rm;
        bit gaps;
        int beats;
        bit err_end;
    } scen_t;

    scen_t tbl[3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step(input logic pv, input int x, input int y,
                        input logic [8:0] p);
        logic r;
        @(negedge clock);
        cyc++;
        if (prev_stall && ({out_last, out_pixel} !== hold))
            stab_bad++;
        if (frame_done)
            done_cnt++;
        if (busy)
            busy_seen = 1'b1;
        case (rmode)
            1:       r = (cyc % 3 == 0);
            2:       r = rdy_var;
            default: r = 1'b1;
        endcase
        out_ready    = r;
        pix_valid    = pv;
        screen_x_pos = 10'(x);
        screen_y_pos = 10'(y);
        test_pixel   = p;
        if (out_valid && r)
            got.push_back({out_last, out_pixel});
        prev_stall = out_valid && !r;
        hold       = {out_last, out_pixel};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 0, 0, 9'd0);
    endtask

    task automatic model(input int cut_y, input int cut_x);
        int x;
        int y;
        for (int r = 0; r < RH; r++) begin
            for (int c = 0; c < RW; c++) begin
                x = RX + DC * c;
                y = RY + DC * r;
                if (cut_y < 0 || y < cut_y || (y == cut_y && x <= cut_x))
                    exp_q.push_back({(r == RH - 1 && c == RW - 1),
                                     img[y][x]});
            end
        end
    endtask

    task automatic run_frame(input int mode, input bit gaps, input int y0,
                             input int cut_y, input int cut_x,
                             input bit add);
        logic [8:0] p;
        bit stop;
        stop = 1'b0;
        for (int y = y0; y < NR && !stop; y++) begin
            for (int x = 0; x < NC && !stop; x++) begin
                p = (mode != 0) ? 9'($urandom) : 9'(x);
                img[y][x] = p;
                if (gaps)
                    while ($urandom_range(7) == 0)
                        step(1'b0, $urandom_range(NC - 1),
                             $urandom_range(NR - 1), 9'($urandom));
                step(1'b1, x, y, p);
                if (y == cut_y && x == cut_x)
                    stop = 1'b1;
            end
        end
        if (add)
            model(cut_y, cut_x);
    endtask

    task automatic wait_done(input string name, input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            step(1'b0, 0, 0, 9'd0);
            n++;
        end
        chk({name, "_done_wait"}, 32'(done_cnt >= target), 32'd1);
        idle(5);
    endtask

    task automatic cmp_seq(input string name, input int nexp);
        int bad;
        bad = -1;
        chk({name, "_beats"}, got.size(), nexp);
        for (int i = 0; i < got.size() && i < nexp; i++) begin
            if (i >= exp_q.size() || got[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_seq: beat %0d got %h expected %h", name, bad,
                     got[bad], (bad < exp_q.size()) ? exp_q[bad] : 10'h3ff);
        end
    endtask

    task automatic clear();
        got.delete();
        exp_q.delete();
        done_cnt   = 0;
        stab_bad   = 0;
        prev_stall = 1'b0;
        busy_seen  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{mode: 0, rm: 0, gaps: 1'b0, beats: 784, err_end: 1'b0};
        tbl[1] = '{mode: 1, rm: 1, gaps: 1'b1, beats: 784, err_end: 1'b0};
        tbl[2] = '{mode: 0, rm: 2, gaps: 1'b0, beats: 32,  err_end: 1'b1};

        reset        = 1'b0;
        enable       = 1'b1;
        pix_valid    = 1'b0;
        screen_x_pos = '0;
        screen_y_pos = '0;
        test_pixel   = '0;
        out_ready    = 1'b1;
        rmode        = 0;
        rdy_var      = 1'b0;
        cyc          = 0;
        clear();

        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pixel", 32'(out_pixel), 32'd0);
        chk("rst_last",  32'(out_last), 32'd0);
        chk("rst_done",  32'(frame_done), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle(3);

        for (int s = 0; s < 3; s++) begin
            clear();
            rmode   = tbl[s].rm;
            rdy_var = 1'b0;
            if (tbl[s].rm == 2) begin
                run_frame(tbl[s].mode, tbl[s].gaps, 0, RY, NC - 1, 1'b0);
                chk("ovf_err_early", 32'(err), 32'd0);
                run_frame(tbl[s].mode, tbl[s].gaps, RY + 1, -1, -1, 1'b0);
                model(-1, -1);
                chk("ovf_no_drain", 32'(got.size()), 32'd0);
                chk("ovf_err", 32'(err), 32'd1);
                rdy_var = 1'b1;
            end else begin
                run_frame(tbl[s].mode, tbl[s].gaps, 0, -1, -1, 1'b1);
            end
            wait_done($sformatf("scen%0d", s), 1);
            cmp_seq($sformatf("scen%0d", s), tbl[s].beats);
            chk($sformatf("scen%0d_err", s), 32'(err), 32'(tbl[s].err_end));
            chk($sformatf("scen%0d_done1", s), done_cnt, 32'd1);
            chk($sformatf("scen%0d_stable", s), stab_bad, 32'd0);
            chk($sformatf("scen%0d_idle", s), 32'(busy), 32'd0);
        end

        // Frame restart after 100 captures.
        clear();
        rmode = 0;
        run_frame(0, 1'b0, 0, RY + 6, RX + 30, 1'b1);
        chk("fsr_err_pre", 32'(err), 32'd0);
        chk("fsr_busy_pre", 32'(busy), 32'd1);
        run_frame(0, 1'b0, 0, -1, -1, 1'b1);
        wait_done("fsr", 1);
        cmp_seq("fsr", 884);
        chk("fsr_err", 32'(err), 32'd1);
        chk("fsr_done1", done_cnt, 32'd1);

        // enable low, then raised mid-frame.
        clear();
        enable = 1'b0;
        run_frame(0, 1'b0, 0, 20, NC - 1, 1'b0);
        enable = 1'b1;
        run_frame(0, 1'b0, 21, -1, -1, 1'b0);
        idle(10);
        chk("en_beats", got.size(), 32'd0);
        chk("en_busy", 32'(busy_seen), 32'd0);
        chk("en_done", done_cnt, 32'd0);
        clear();
        run_frame(0, 1'b0, 0, -1, -1, 1'b1);
        wait_done("en", 1);
        cmp_seq("en", 784);
        chk("en_err", 32'(err), 32'd0);

        // Asynchronous reset mid-capture.
        clear();
        rmode   = 2;
        rdy_var = 1'b0;
        run_frame(1, 1'b0, 0, 30, 40, 1'b0);
        @(negedge clock);
        pix_valid = 1'b0;
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_busy", 32'(busy), 32'd1);
        chk("ar_pre_err", 32'(err), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_pixel", 32'(out_pixel), 32'd0);
        chk("ar_last", 32'(out_last), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_err", 32'(err), 32'd0);
        chk("ar_done", 32'(frame_done), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        clear();
        rmode = 0;
        run_frame(1, 1'b1, 0, -1, -1, 1'b1);
        wait_done("ar", 1);
        cmp_seq("ar", 784);
        chk("ar_err_end", 32'(err), 32'd0);
        chk("ar_done1", done_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
